// File: rtl/deadlock_confirm_monitor_if.sv
// Report channel from the deadlock confirmation stage to the bench logger.
// The master side presents the report; the slave side accepts it with ready.
interface deadlock_confirm_monitor_if #(
    parameter int INST_NUM = 5,
    parameter int AXIS_NUM = 2,
    parameter int TS_W     = 32
);
    logic                report_valid;
    logic                report_ready;
    logic [INST_NUM-1:0] report_inst_mask;
    logic [AXIS_NUM-1:0] report_axis_mask;
    logic [TS_W-1:0]     report_start_ts;

    modport master (
        output report_valid,
        output report_inst_mask,
        output report_axis_mask,
        output report_start_ts,
        input  report_ready
    );

    modport slave (
        input  report_valid,
        input  report_inst_mask,
        input  report_axis_mask,
        input  report_start_ts,
        output report_ready
    );
endinterface

// File: rtl/deadlock_confirm_monitor.sv
// Confirms persistent kernel blocks, filters short glitches and emits exactly one
// snapshot report per confirmed episode over a valid/ready channel.
module deadlock_confirm_monitor #(
    parameter int INST_NUM       = 5,
    parameter int AXIS_NUM       = 2,
    parameter int CONFIRM_CYCLES = 16,
    parameter int TS_W           = 32
) (
    input  logic                kernel_monitor_clock,
    input  logic                kernel_monitor_reset,
    input  logic                block_in,
    input  logic [INST_NUM-1:0] inst_block_sigs,
    input  logic [AXIS_NUM-1:0] axis_block_sigs,
    deadlock_confirm_monitor_if.master report,
    output logic                deadlock_now,
    output logic                deadlock_seen,
    output logic [15:0]         glitch_count
);
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PENDING   = 2'd1,
        ST_REPORT    = 2'd2,
        ST_CONFIRMED = 2'd3
    } state_e;

    localparam logic [16:0] CONFIRM_L = 17'(CONFIRM_CYCLES);

    state_e              state_q, state_d;
    logic [15:0]         pend_cnt_q, pend_cnt_d;
    logic [TS_W-1:0]     cycle_cnt_q;
    logic [TS_W-1:0]     pend_ts_q, pend_ts_d;
    logic [TS_W-1:0]     rep_ts_q, rep_ts_d;
    logic [INST_NUM-1:0] inst_mask_q, inst_mask_d;
    logic [AXIS_NUM-1:0] axis_mask_q, axis_mask_d;
    logic [15:0]         glitch_q, glitch_d;
    logic                seen_q, seen_d;
    logic                valid_q, valid_d;
    logic                now_q, now_d;
    logic [16:0]         pend_inc_s;

    assign pend_inc_s = {1'b0, pend_cnt_q} + 17'd1;

    // State, datapath and registered-output flops
    always_ff @(posedge kernel_monitor_clock) begin
        if (kernel_monitor_reset) begin
            state_q     <= ST_IDLE;
            pend_cnt_q  <= 16'd0;
            cycle_cnt_q <= '0;
            pend_ts_q   <= '0;
            rep_ts_q    <= '0;
            inst_mask_q <= '0;
            axis_mask_q <= '0;
            glitch_q    <= 16'd0;
            seen_q      <= 1'b0;
            valid_q     <= 1'b0;
            now_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_cnt_q  <= pend_cnt_d;
            cycle_cnt_q <= cycle_cnt_q + TS_W'(1);
            pend_ts_q   <= pend_ts_d;
            rep_ts_q    <= rep_ts_d;
            inst_mask_q <= inst_mask_d;
            axis_mask_q <= axis_mask_d;
            glitch_q    <= glitch_d;
            seen_q      <= seen_d;
            valid_q     <= valid_d;
            now_q       <= now_d;
        end
    end

    // Next-state and snapshot capture
    always_comb begin
        state_d     = state_q;
        pend_cnt_d  = pend_cnt_q;
        pend_ts_d   = pend_ts_q;
        rep_ts_d    = rep_ts_q;
        inst_mask_d = inst_mask_q;
        axis_mask_d = axis_mask_q;
        glitch_d    = glitch_q;
        seen_d      = seen_q;
        case (state_q)
            ST_IDLE: begin
                if (block_in) begin
                    pend_ts_d = cycle_cnt_q;
                    if (CONFIRM_L == 17'd1) begin
                        state_d     = ST_REPORT;
                        rep_ts_d    = cycle_cnt_q;
                        inst_mask_d = inst_block_sigs;
                        axis_mask_d = axis_block_sigs;
                        seen_d      = 1'b1;
                        pend_cnt_d  = 16'd0;
                    end else begin
                        state_d    = ST_PENDING;
                        pend_cnt_d = 16'd1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (!block_in) begin
                    state_d    = ST_IDLE;
                    pend_cnt_d = 16'd0;
                    if (glitch_q != 16'hFFFF) begin
                        glitch_d = glitch_q + 16'd1;
                    end else begin
                        glitch_d = glitch_q;
                    end
                end else if (pend_inc_s == CONFIRM_L) begin
                    // Snapshot the vectors seen on the confirming sample itself
                    state_d     = ST_REPORT;
                    rep_ts_d    = pend_ts_q;
                    inst_mask_d = inst_block_sigs;
                    axis_mask_d = axis_block_sigs;
                    seen_d      = 1'b1;
                    pend_cnt_d  = 16'd0;
                end else begin
                    pend_cnt_d = pend_inc_s[15:0];
                end
            end
            ST_REPORT: begin
                if (report.report_ready) begin
                    state_d = ST_CONFIRMED;
                end else begin
                    state_d = ST_REPORT;
                end
            end
            ST_CONFIRMED: begin
                if (!block_in) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CONFIRMED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the flags land registered
    always_comb begin
        valid_d = 1'b0;
        now_d   = 1'b0;
        case (state_d)
            ST_REPORT: begin
                valid_d = 1'b1;
                now_d   = 1'b1;
            end
            ST_CONFIRMED: begin
                valid_d = 1'b0;
                now_d   = 1'b1;
            end
            default: begin
                valid_d = 1'b0;
                now_d   = 1'b0;
            end
        endcase
    end

    assign report.report_valid     = valid_q;
    assign report.report_inst_mask = inst_mask_q;
    assign report.report_axis_mask = axis_mask_q;
    assign report.report_start_ts  = rep_ts_q;
    assign deadlock_now            = now_q;
    assign deadlock_seen           = seen_q;
    assign glitch_count            = glitch_q;
endmodule

// File: tb/tb_deadlock_confirm_monitor.sv
// Two monitors (16-cycle window with wide timestamp, 1-cycle window with 8-bit
// timestamp) share one random stimulus and are checked against a run-length model.
module tb_deadlock_confirm_monitor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       blk = 1'b0;
    logic       ready = 1'b0;
    logic [4:0] inst = 5'd0;
    logic [1:0] axis = 2'd0;
    bit         chk_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    deadlock_confirm_monitor_if #(.INST_NUM(5), .AXIS_NUM(2), .TS_W(32)) rif16 ();
    deadlock_confirm_monitor_if #(.INST_NUM(5), .AXIS_NUM(2), .TS_W(8))  rif1 ();
    assign rif16.report_ready = ready;
    assign rif1.report_ready  = ready;

    logic        now16, seen16, now1, seen1;
    logic [15:0] gl16, gl1;

    deadlock_confirm_monitor #(.INST_NUM(5), .AXIS_NUM(2), .CONFIRM_CYCLES(16), .TS_W(32)) u16 (
        .kernel_monitor_clock(clk), .kernel_monitor_reset(rst), .block_in(blk),
        .inst_block_sigs(inst), .axis_block_sigs(axis), .report(rif16.master),
        .deadlock_now(now16), .deadlock_seen(seen16), .glitch_count(gl16));

    deadlock_confirm_monitor #(.INST_NUM(5), .AXIS_NUM(2), .CONFIRM_CYCLES(1), .TS_W(8)) u1 (
        .kernel_monitor_clock(clk), .kernel_monitor_reset(rst), .block_in(blk),
        .inst_block_sigs(inst), .axis_block_sigs(axis), .report(rif1.master),
        .deadlock_now(now1), .deadlock_seen(seen1), .glitch_count(gl1));

    logic [31:0] d_valid[2], d_now[2], d_seen[2], d_glitch[2], d_inst[2], d_axis[2], d_ts[2];
    assign d_valid[0]  = {31'd0, rif16.report_valid};
    assign d_valid[1]  = {31'd0, rif1.report_valid};
    assign d_now[0]    = {31'd0, now16};
    assign d_now[1]    = {31'd0, now1};
    assign d_seen[0]   = {31'd0, seen16};
    assign d_seen[1]   = {31'd0, seen1};
    assign d_glitch[0] = {16'd0, gl16};
    assign d_glitch[1] = {16'd0, gl1};
    assign d_inst[0]   = {27'd0, rif16.report_inst_mask};
    assign d_inst[1]   = {27'd0, rif1.report_inst_mask};
    assign d_axis[0]   = {30'd0, rif16.report_axis_mask};
    assign d_axis[1]   = {30'd0, rif1.report_axis_mask};
    assign d_ts[0]     = rif16.report_start_ts;
    assign d_ts[1]     = {24'd0, rif1.report_start_ts};

    // Reference model: length of the current high run, pending/live report flags
    typedef struct {
        logic [31:0] inst;
        logic [31:0] axis;
        logic [31:0] ts;
    } rep_t;
    rep_t sb0[$];
    rep_t sb1[$];

    int          win[2]    = '{16, 1};
    logic [31:0] tsmask[2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
    int          m_run[2];
    bit          m_pend[2], m_live[2], m_seen[2];
    int          m_glitch[2];
    logic [31:0] m_cnt[2], m_start[2], m_inst[2], m_axis[2], m_ts[2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_run[k] = 0; m_pend[k] = 1'b0; m_live[k] = 1'b0; m_seen[k] = 1'b0;
                m_glitch[k] = 0; m_cnt[k] = 32'd0; m_start[k] = 32'd0;
                m_inst[k] = 32'd0; m_axis[k] = 32'd0; m_ts[k] = 32'd0;
                if (k == 0) sb0.delete(); else sb1.delete();
            end else begin
                if (m_pend[k]) begin
                    if (ready) m_pend[k] = 1'b0;
                end else if (m_live[k]) begin
                    if (!blk) m_live[k] = 1'b0;
                end else if (blk) begin
                    m_run[k] = m_run[k] + 1;
                    if (m_run[k] == 1) m_start[k] = m_cnt[k];
                    if (m_run[k] == win[k]) begin
                        rep_t r;
                        m_inst[k] = {27'd0, inst};
                        m_axis[k] = {30'd0, axis};
                        m_ts[k]   = m_start[k];
                        r.inst = m_inst[k]; r.axis = m_axis[k]; r.ts = m_ts[k];
                        if (k == 0) sb0.push_back(r); else sb1.push_back(r);
                        m_pend[k] = 1'b1; m_live[k] = 1'b1; m_seen[k] = 1'b1; m_run[k] = 0;
                    end
                end else begin
                    if (m_run[k] > 0 && m_glitch[k] < 65535) m_glitch[k] = m_glitch[k] + 1;
                    m_run[k] = 0;
                end
                m_cnt[k] = (m_cnt[k] + 32'd1) & tsmask[k];
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] t=%0t got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    // Per-cycle flag checks and scoreboard pops on each accepted report
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("valid", k, d_valid[k], {31'd0, m_pend[k]});
                chk("now", k, d_now[k], {31'd0, m_live[k]});
                chk("seen", k, d_seen[k], {31'd0, m_seen[k]});
                chk("glitch", k, d_glitch[k], m_glitch[k]);
                chk("inst_mask", k, d_inst[k], m_inst[k]);
                chk("axis_mask", k, d_axis[k], m_axis[k]);
                chk("start_ts", k, d_ts[k], m_ts[k]);
                if (d_valid[k][0] && ready) begin
                    rep_t e;
                    int   sz;
                    sz = (k == 0) ? sb0.size() : sb1.size();
                    chk("sb_nonempty", k, (sz > 0) ? 32'd1 : 32'd0, 32'd1);
                    if (sz > 0) begin
                        e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                        chk("xfer_inst", k, d_inst[k], e.inst);
                        chk("xfer_axis", k, d_axis[k], e.axis);
                        chk("xfer_ts", k, d_ts[k], e.ts);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic step(input bit b, input bit r);
        blk   = b;
        ready = r;
        inst  = 5'($urandom);
        axis  = 2'($urandom);
        tick();
    endtask

    initial begin
        int g;
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) step(1'b0, 1'b1);
        // Short run rejected by the 16-cycle window
        repeat (15) step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1);
        // Episode starting at timestamp 100 with ready held high
        g = 0;
        while (m_cnt[0] != 32'd100 && g < 500) begin
            step(1'b0, 1'b1);
            g++;
        end
        repeat (20) step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1);
        // Ready withheld for several cycles while inputs keep changing
        repeat (21) step(1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        // Back-to-back episodes separated by one low cycle
        repeat (20) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        repeat (18) step(1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b1);
        // Single-cycle pulse
        step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1);
        // Reset while a report is waiting
        repeat (17) step(1'b1, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b0);
        rst = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        // Random episodes, ready and occasional resets
        repeat (150) begin
            int hl;
            hl = $urandom_range(1, 24);
            for (int i = 0; i < hl; i++) step(1'b1, ($urandom % 3) != 0);
            hl = $urandom_range(1, 3);
            for (int i = 0; i < hl; i++) begin
                rst = (($urandom % 200) == 0);
                step(1'b0, ($urandom % 3) != 0);
                rst = 1'b0;
            end
        end
        repeat (30) step(1'b0, 1'b1);
        chk("sb_drained", 0, sb0.size(), 32'd0);
        chk("sb_drained", 1, sb1.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
